// File: rtl/uart_msg_arbiter_if.sv
// Bundle between the response-message FIFOs, the host UART TX port and
// the round-robin message arbiter that shares that UART.
interface uart_msg_arbiter_if #(
    parameter int NUM_SRC   = 2,
    parameter int MSG_BYTES = 5
);
    localparam int W = 8 * MSG_BYTES;

    logic [NUM_SRC*W-1:0] src_data;
    logic [NUM_SRC-1:0]   src_ready;
    logic [NUM_SRC-1:0]   src_ack;
    logic [7:0]           tx_byte;
    logic                 tx_req;
    logic                 tx_busy;
    logic [NUM_SRC-1:0]   grant;
    logic                 active;
    logic [15:0]          sent_count;

    modport master (
        input  src_data, src_ready, tx_busy,
        output src_ack, tx_byte, tx_req, grant, active, sent_count
    );

    modport slave (
        output src_data, src_ready, tx_busy,
        input  src_ack, tx_byte, tx_req, grant, active, sent_count
    );
endinterface

// File: rtl/uart_msg_arbiter.sv
// Round-robin arbiter serializing 40-bit response messages onto the host UART.
// Optional XOR checksum trailer byte: define UARTARB_CHECKSUM_EN.
module uart_msg_arbiter #(
    parameter int NUM_SRC   = 2,
    parameter int MSG_BYTES = 5
) (
    input  logic                clk,
    input  logic                reset,
    uart_msg_arbiter_if.master  bus
);
    localparam int W  = 8 * MSG_BYTES;
    localparam int LW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CW = $clog2(MSG_BYTES + 1);

`ifdef UARTARB_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, SEND, TAIL, DRAIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;
`endif

    state_t               state_q, state_d;
    logic [LW-1:0]        last_q, last_d;
    logic [W-1:0]         shift_q, shift_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_SRC-1:0]   grant_q, grant_d;
    logic [NUM_SRC-1:0]   ack_q, ack_d;
    logic [7:0]           byte_q, byte_d;
    logic                 req_q, req_d;
    logic [15:0]          sent_q, sent_d;
`ifdef UARTARB_CHECKSUM_EN
    logic [7:0]           chk_q, chk_d;
`endif

    logic                 win_found;
    logic [LW-1:0]        win_idx;
    logic [LW:0]          cand;
    logic                 uart_free;

    // The UART may raise tx_busy only one cycle after a request, so a
    // pending request also blocks the next byte.
    assign uart_free = !bus.tx_busy && !req_q;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = {1'b0, last_q} + (LW+1)'(k);
            if (cand >= (LW+1)'(NUM_SRC))
                cand = cand - (LW+1)'(NUM_SRC);
            if (!win_found && bus.src_ready[cand[LW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[LW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        ack_d   = '0;
        byte_d  = byte_q;
        req_d   = 1'b0;
        sent_d  = sent_q;
`ifdef UARTARB_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    shift_d          = bus.src_data[int'(win_idx)*W +: W];
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    ack_d[win_idx]   = 1'b1;
                    last_d           = win_idx;
                    cnt_d            = '0;
`ifdef UARTARB_CHECKSUM_EN
                    chk_d            = '0;
`endif
                    state_d          = SEND;
                end
            end
            SEND: begin
                if (uart_free) begin
                    byte_d  = shift_q[7:0];
                    req_d   = 1'b1;
                    shift_d = shift_q >> 8;
                    cnt_d   = cnt_q + 1'b1;
`ifdef UARTARB_CHECKSUM_EN
                    chk_d   = chk_q ^ shift_q[7:0];
                    if (cnt_q == CW'(MSG_BYTES - 1))
                        state_d = TAIL;
`else
                    if (cnt_q == CW'(MSG_BYTES - 1))
                        state_d = DRAIN;
`endif
                end
            end
`ifdef UARTARB_CHECKSUM_EN
            TAIL: begin
                if (uart_free) begin
                    byte_d  = chk_q;
                    req_d   = 1'b1;
                    state_d = DRAIN;
                end
            end
`endif
            DRAIN: begin
                if (uart_free) begin
                    sent_d  = sent_q + 16'd1;
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= LW'(NUM_SRC - 1);
            shift_q <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            byte_q  <= '0;
            req_q   <= 1'b0;
            sent_q  <= '0;
`ifdef UARTARB_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            byte_q  <= byte_d;
            req_q   <= req_d;
            sent_q  <= sent_d;
`ifdef UARTARB_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    assign bus.src_ack    = ack_q;
    assign bus.tx_byte    = byte_q;
    assign bus.tx_req     = req_q;
    assign bus.grant      = grant_q;
    assign bus.active     = (state_q != IDLE);
    assign bus.sent_count = sent_q;
endmodule

// File: doc/uart_msg_arbiter.md
# uart_msg_arbiter

Shares the single host UART transmitter among several 40-bit response-message sources, such as the local MIC-hit/finished FIFO and the forwarded auxiliary-UART FIFO. Sources are served with round-robin arbitration. The arbiter latches the granted message, pops it from its FIFO with a single-cycle acknowledge, and serializes it LSB byte first onto the UART byte interface under the UART's `tx_req`/`tx_busy` handshake. It sits between the response FIFOs and the `uart` TX port in the bruteforcer toplevel.

## Interface
Parameters:
- `NUM_SRC`, default 2: number of message sources (2..8).
- `MSG_BYTES`, default 5: bytes per message; message width W = 8·`MSG_BYTES`.

Ports:
- `clk`, in, 1: system clock. There is one clock.
- `reset`, in, 1: synchronous, active-high reset.
- `src_data`, in, `NUM_SRC`·W: packed messages; source i occupies `[i*W +: W]`.
- `src_ready`, in, `NUM_SRC`: source i holds a valid message (FIFO `rd_ready`).
- `src_ack`, out, `NUM_SRC`: one-cycle pop pulse to source i (FIFO `rd_ack`).
- `tx_byte`, out, 8: byte to the UART.
- `tx_req`, out, 1: one-cycle transmit request.
- `tx_busy`, in, 1: UART transmitter busy.
- `grant`, out, `NUM_SRC`: one-hot owner of the current message; 0 when idle.
- `active`, out, 1: the arbiter owns the UART.
- `sent_count`, out, 16: number of completed messages; wraps modulo 2^16.

## Operation
- State IDLE: compute a round-robin search starting at `(last+1) mod NUM_SRC`. The first index with `src_ready` set wins.
  - On a win: load shift register ← that source's slice; load checksum ← 0 (when enabled); set `grant` one-hot; set `last` ← winner; set `src_ack[winner]` for exactly one cycle; clear `byte_cnt`; go to SEND.
  - With no request: stay in IDLE.
- State SEND: when `!tx_busy && !tx_req`:
  - Drive `tx_byte` ← shift[7:0] and pulse `tx_req`.
  - Shift right 8; XOR the byte into the checksum; increment `byte_cnt`.
  - After the byte where `byte_cnt` reaches `MSG_BYTES`, go to TAIL (macro defined) or DRAIN (macro not defined).
- State TAIL: when `!tx_busy && !tx_req`, send the checksum byte, then go to DRAIN.
- State DRAIN: when `!tx_busy && !tx_req`, increment `sent_count`, clear `grant`, and go to IDLE.
- The message is latched at grant, so later changes to `src_data`/`src_ready` of the owner do not affect it.
- `src_ack` is never asserted outside the IDLE→SEND transition.
- `src_ack` is never asserted for a source whose `src_ready` was 0 in the deciding cycle.
- `last` resets to `NUM_SRC-1`, so source 0 wins the first tie after reset.
- A continuously requesting source cannot starve others: every other requester is served within `NUM_SRC-1` messages.

## Timing
- Reset values:
  - `src_ack`=0, `tx_req`=0, `tx_byte`=0, `grant`=0, `active`=0, `sent_count`=0.
  - State=IDLE, `last`=`NUM_SRC-1`.
- Reset mid-message aborts it: the remaining bytes are dropped, nothing is re-acked, and a byte already handed to the UART is not recalled.
- Request at cycle T in IDLE produces, at T+1 (registered): `grant`, `active`=1, `src_ack` pulse, state SEND.
- The first `tx_req` comes no earlier than T+2, and only when `tx_busy` is low.
- Consecutive `tx_req` pulses are separated by at least one low cycle, because `tx_busy` may rise one cycle after the request.
- With an idle UART answering busy for B cycles per byte, one message occupies the UART for approximately `MSG_BYTES`·(B+2) cycles.
- The next arbitration takes place the cycle after DRAIN exits.
- `active` = (state ≠ IDLE).
- `sent_count` updates in the DRAIN exit cycle.

## Configuration
- `UARTARB_CHECKSUM_EN` defined: an extra byte, the XOR of all `MSG_BYTES` payload bytes, is appended after each message, for `MSG_BYTES`+1 bytes per message.
- `UARTARB_CHECKSUM_EN` undefined: exactly `MSG_BYTES` bytes are sent; the TAIL state and checksum register are absent.

## Test plan
- Single message: src0 `40'h5544332211`, `tx_busy` modelled at 10 cycles per byte → bytes 11,22,33,44,55 in order; `src_ack[0]` high for exactly 1 cycle; `sent_count`=1; `grant` returns to 0.
- Tie fairness: both sources ready from reset with 2 messages each → service order src0, src1, src0, src1; 4 `src_ack` pulses total.
- Starvation: src1 always ready, src0 raises ready during a src1 message → the next message served is src0.
- Back-pressure: `tx_busy` held high for 100 cycles mid-message → no `tx_req` while high; the sequence resumes with no byte lost or duplicated.
- Reset after byte 2 of src0 → the next cycle has `tx_req`=0, `grant`=0, `sent_count`=0; the following message starts at byte 0, with src0 preferred on a tie.
- With `UARTARB_CHECKSUM_EN`: `40'h5544332211` → 6 bytes, the last being 0x11; `40'h0` → last byte 0x00.
